// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the 5-stage RISC-V pipeline control logic.
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } hc_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  // True when a stage writing register rd produces the value a consumer reads from src.
  function automatic logic reg_match(input logic we, input logic [4:0] rd, input logic [4:0] src);
    return we && (rd != REG_X0) && (rd == src);
  endfunction

endpackage

// File: rtl/hazard_forward_unit.sv
// Combinational forwarding select for one EX operand; EX/MEM beats MEM/WB.
module hazard_forward_unit
  import riscv_pipe_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] ex_mem_rd,
  input  logic       ex_mem_regwrite,
  input  logic [4:0] mem_wb_rd,
  input  logic       mem_wb_regwrite,
  output logic [1:0] fwd_sel
);

  fwd_sel_t sel;

  // Pick the youngest in-flight producer of src, else the register file.
  always_comb begin
    sel = FWD_REG;
    if (reg_match(ex_mem_regwrite, ex_mem_rd, src))
      sel = FWD_MEM;
    else if (reg_match(mem_wb_regwrite, mem_wb_rd, src))
      sel = FWD_WB;
  end

  assign fwd_sel = sel;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/forwarding controller and multi-cycle execute sequencer.
// Build option: define FORWARDING_EN to enable operand forwarding; without it
// every RAW dependency on an in-flight writer stalls the ID instruction.
module pipeline_hazard_controller
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned MC_TIMEOUT  = 64,
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             if_id_rs1,
  input  logic [4:0]             if_id_rs2,
  input  logic                   if_id_use_rs1,
  input  logic                   if_id_use_rs2,
  input  logic [4:0]             id_ex_rs1,
  input  logic [4:0]             id_ex_rs2,
  input  logic [4:0]             id_ex_rd,
  input  logic                   id_ex_regwrite,
  input  logic                   id_ex_memread,
  input  logic [4:0]             ex_mem_rd,
  input  logic [4:0]             mem_wb_rd,
  input  logic                   ex_mem_regwrite,
  input  logic                   mem_wb_regwrite,
  input  logic                   ex_branch_taken,
  input  logic                   ex_mc_start,
  input  logic                   mc_done,
  output logic                   pc_stall,
  output logic                   if_id_stall,
  output logic                   id_ex_stall,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   ex_mem_bubble,
  output logic [1:0]             forward_a,
  output logic [1:0]             forward_b,
  output logic                   mc_busy,
  output logic                   mc_error,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int unsigned TW = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(MC_TIMEOUT - 1);

  hc_state_t              state, state_next;
  logic [TW-1:0]          tcnt;
  logic                   mc_timeout;
  logic                   err_q;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic                   data_hazard;
  logic [1:0]             fwd_a_raw, fwd_b_raw;

  // RAW check of one used ID source against a stage that writes a register.
  function automatic logic src_hit(input logic we, input logic [4:0] rd);
    return (if_id_use_rs1 && reg_match(we, rd, if_id_rs1)) ||
           (if_id_use_rs2 && reg_match(we, rd, if_id_rs2));
  endfunction

`ifdef FORWARDING_EN
  hazard_forward_unit u_fwd_a (
    .src             (id_ex_rs1),
    .ex_mem_rd       (ex_mem_rd),
    .ex_mem_regwrite (ex_mem_regwrite),
    .mem_wb_rd       (mem_wb_rd),
    .mem_wb_regwrite (mem_wb_regwrite),
    .fwd_sel         (fwd_a_raw)
  );

  hazard_forward_unit u_fwd_b (
    .src             (id_ex_rs2),
    .ex_mem_rd       (ex_mem_rd),
    .ex_mem_regwrite (ex_mem_regwrite),
    .mem_wb_rd       (mem_wb_rd),
    .mem_wb_regwrite (mem_wb_regwrite),
    .fwd_sel         (fwd_b_raw)
  );

  // Only a load in EX cannot be forwarded in time.
  assign data_hazard = src_hit(id_ex_memread, id_ex_rd);
`else
  logic unused_ex_srcs;
  assign unused_ex_srcs = ^{id_ex_rs1, id_ex_rs2};
  assign fwd_a_raw = FWD_REG;
  assign fwd_b_raw = FWD_REG;

  // Without forwarding, wait until every in-flight writer has retired.
  assign data_hazard = src_hit(id_ex_regwrite | id_ex_memread, id_ex_rd) |
                       src_hit(ex_mem_regwrite, ex_mem_rd) |
                       src_hit(mem_wb_regwrite, mem_wb_rd);
`endif

  assign forward_a = reset ? '0 : fwd_a_raw;
  assign forward_b = reset ? '0 : fwd_b_raw;

  // Next state and pipeline controls, in priority order reset > MC_WAIT > mc start > branch > hazard.
  always_comb begin
    state_next    = state;
    mc_timeout    = 1'b0;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    if (reset) begin
      state_next = RUN;
    end else if (state == MC_WAIT) begin
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      id_ex_stall   = 1'b1;
      ex_mem_bubble = !mc_done;
      mc_timeout    = !mc_done && (tcnt == T_LAST);
      if (mc_done || mc_timeout)
        state_next = RUN;
    end else if (ex_mc_start) begin
      if (!mc_done)
        state_next = MC_WAIT;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (data_hazard) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  // State, timeout counter, sticky error and saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      tcnt      <= '0;
      err_q     <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == MC_WAIT && state_next == MC_WAIT)
        tcnt <= tcnt + TW'(1);
      else
        tcnt <= '0;
      if (mc_timeout)
        err_q <= 1'b1;
      if (pc_stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign mc_busy      = !reset && (state == MC_WAIT);
  assign mc_error     = !reset && err_q;
  assign stall_cycles = reset ? '0 : stall_cnt;

endmodule
